// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: in-place radix-2 FFT/IFFT frame sequencer time-sharing one external butterfly.
// Optional macro FFT_SAT_EN: clip write-back to [-128,127] and report clips on sat_flag.
module fft_seq_ctrl #(
  parameter int LOG2N = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [7:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [7:0]      out_data,
  input  logic                   tw_we,
  input  logic [LOG2N-2:0]       tw_addr,
  input  logic signed [7:0]      tw_data,
  output logic signed [7:0]      bf_a,
  output logic signed [7:0]      bf_b,
  output logic signed [7:0]      bf_w,
  output logic                   bf_s,
  input  logic signed [15:0]     bf_out_a,
  input  logic signed [15:0]     bf_out_b,
  output logic                   busy,
  output logic                   sat_flag
);
  localparam int N  = 1 << LOG2N;
  localparam int H  = N / 2;
  localparam int SW = $clog2(LOG2N);
  localparam logic [LOG2N-1:0] LAST_K = '1;
  localparam logic [LOG2N-2:0] LAST_J = '1;
  localparam logic [SW-1:0]    LAST_S = SW'(LOG2N - 1);
  localparam logic [LOG2N-1:0] ONE    = LOG2N'(1);

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [LOG2N-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     stage_q, stage_d;
  logic [LOG2N-2:0]  bfly_q, bfly_d;
  logic              mode_q, mode_d;
  logic signed [7:0] mem_q [N];
  logic signed [7:0] mem_d [N];
  logic signed [7:0] tw_q [H];
  logic signed [7:0] tw_d [H];

  logic [SW-1:0]     sh, osh;
  logic [LOG2N-1:0]  jx, half, p, top, bot, idx_full;
  logic [LOG2N-2:0]  idx;
  logic signed [7:0] na, nb;
  logic              unused_ok;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    for (int unsigned i = 0; i < LOG2N; i++) r[i] = k[LOG2N-1-i];
    return r;
  endfunction

  // Span shift (sh) and twiddle shift (osh) swap roles between DIT and DIF.
  always_comb begin
    sh       = mode_q ? LAST_S - stage_q : stage_q;
    osh      = mode_q ? stage_q : LAST_S - stage_q;
    jx       = {1'b0, bfly_q};
    half     = ONE << sh;
    p        = jx & (half - ONE);
    top      = (((jx >> sh) << sh) << 1) | p;
    bot      = top | half;
    idx_full = p << osh;
    idx      = idx_full[LOG2N-2:0];
  end

`ifdef FFT_SAT_EN
  logic sat_q, sat_d;
  logic clip_any;

  function automatic logic signed [7:0] sat8(input logic signed [15:0] v);
    if (v > 16'sd127)       return 8'sd127;
    else if (v < -16'sd128) return 8'sh80;
    else                    return v[7:0];
  endfunction

  assign na        = sat8(bf_out_a);
  assign nb        = sat8(bf_out_b);
  assign clip_any  = (bf_out_a > 16'sd127) || (bf_out_a < -16'sd128) ||
                     (bf_out_b > 16'sd127) || (bf_out_b < -16'sd128);
  assign sat_flag  = sat_q;
  assign unused_ok = idx_full[LOG2N-1];
`else
  assign na        = bf_out_a[7:0];
  assign nb        = bf_out_b[7:0];
  assign sat_flag  = 1'b0;
  assign unused_ok = ^{bf_out_a[15:8], bf_out_b[15:8], idx_full[LOG2N-1]};
`endif

  assign bf_s = mode_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    bfly_d    = bfly_q;
    mode_d    = mode_q;
    mem_d     = mem_q;
    tw_d      = tw_q;
`ifdef FFT_SAT_EN
    sat_d     = sat_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    bf_a      = '0;
    bf_b      = '0;
    bf_w      = '0;

    if (tw_we && state_q != S_CALC) tw_d[tw_addr] = tw_data;

    unique case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (cnt_q == '0) begin
            mode_d = mode;
`ifdef FFT_SAT_EN
            sat_d  = 1'b0;
`endif
          end
          mem_d[mode_d ? cnt_q : bitrev(cnt_q)] = in_data;
          cnt_d = cnt_q + ONE;
          if (cnt_q == LAST_K) state_d = S_CALC;
        end
      end
      S_CALC: begin
        busy       = 1'b1;
        bf_a       = mem_q[top];
        bf_b       = mem_q[bot];
        bf_w       = tw_q[idx];
        mem_d[top] = na;
        mem_d[bot] = nb;
`ifdef FFT_SAT_EN
        if (clip_any) sat_d = 1'b1;
`endif
        bfly_d = bfly_q + 1'b1;
        if (bfly_q == LAST_J) begin
          if (stage_q == LAST_S) begin
            stage_d = '0;
            state_d = S_DRAIN;
          end else begin
            stage_d = stage_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_data  = mem_q[mode_q ? bitrev(cnt_q) : cnt_q];
        if (out_ready) begin
          cnt_d = cnt_q + ONE;
          if (cnt_q == LAST_K) state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      stage_q <= '0;
      bfly_q  <= '0;
      mode_q  <= 1'b0;
      for (int unsigned i = 0; i < N; i++) mem_q[i] <= '0;
      for (int unsigned i = 0; i < H; i++) tw_q[i] <= 8'sd1;
`ifdef FFT_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      mode_q  <= mode_d;
      mem_q   <= mem_d;
      tw_q    <= tw_d;
`ifdef FFT_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

endmodule
